// File: rtl/spi_trace_tx_if.sv
// Trace-serializer bundle: core-side capture request and trace words, plus the
// status flags and per-channel SPI pins driven back out.
interface spi_trace_tx_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       chan_en;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] imem_data;
  logic [WIDTH-1:0] dmem_wdata;
  logic [WIDTH-1:0] dmem_rdata;
  logic             busy;
  logic             done;
  logic             overrun;
  logic             spi_sck;
  logic             pc_mosi;
  logic             imem_data_mosi;
  logic             dmem_wdata_mosi;
  logic             dmem_rdata_mosi;
  logic             pc_cs;
  logic             imem_data_cs;
  logic             dmem_wdata_cs;
  logic             dmem_rdata_cs;

  modport master (
    output start, chan_en, pc, imem_data, dmem_wdata, dmem_rdata,
    input  busy, done, overrun, spi_sck,
    input  pc_mosi, imem_data_mosi, dmem_wdata_mosi, dmem_rdata_mosi,
    input  pc_cs, imem_data_cs, dmem_wdata_cs, dmem_rdata_cs
  );

  modport slave (
    input  start, chan_en, pc, imem_data, dmem_wdata, dmem_rdata,
    output busy, done, overrun, spi_sck,
    output pc_mosi, imem_data_mosi, dmem_wdata_mosi, dmem_rdata_mosi,
    output pc_cs, imem_data_cs, dmem_wdata_cs, dmem_rdata_cs
  );
endinterface

// File: rtl/spi_trace_tx.sv
// Four-channel mode-0 SPI trace serializer with one shared SCK; every pin is
// driven directly from a flop so the LED/probe outputs never glitch.
module spi_trace_tx #(
  parameter int WIDTH  = 32,
  parameter int CLKDIV = 2
) (
  input logic           clk,
  input logic           rst,
  spi_trace_tx_if.slave bus
);
  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO} state_t;

  state_t                 state, state_n;
  logic [DIV_W-1:0]       div_cnt, div_cnt_n;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [3:0]             en_q, en_n;
  logic [3:0][WIDTH-1:0]  sh_q, sh_n;
  logic                   busy_q, busy_n;
  logic                   done_q, done_n;
  logic                   ovr_q, ovr_n;
  logic                   sck_q, sck_n;
  logic [3:0]             mosi_q, mosi_n;
  logic [3:0]             cs_q, cs_n;
  logic [3:0][WIDTH-1:0]  words;
  logic                   phase_end;

  // Channel index 0 is pc, matching chan_en bit order.
  assign words     = {bus.dmem_rdata, bus.dmem_wdata, bus.imem_data, bus.pc};
  assign phase_end = (div_cnt == DIV_LAST);

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    en_n      = en_q;
    sh_n      = sh_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    ovr_n     = 1'b0;
    sck_n     = sck_q;
    mosi_n    = mosi_q;
    cs_n      = cs_q;

    if (state != IDLE) begin
      div_cnt_n = phase_end ? '0 : div_cnt + 1'b1;
      ovr_n     = bus.start;
    end

    unique case (state)
      IDLE: begin
        busy_n    = 1'b0;
        sck_n     = 1'b0;
        mosi_n    = '0;
        cs_n      = '1;
        div_cnt_n = '0;
        bit_cnt_n = '0;
        if (bus.start) begin
          state_n = SETUP;
          busy_n  = 1'b1;
          en_n    = bus.chan_en;
          sh_n    = words;
          cs_n    = ~bus.chan_en;
          for (int i = 0; i < 4; i++) mosi_n[i] = bus.chan_en[i] & words[i][WIDTH-1];
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_n = SHIFT_HI;
          sck_n   = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          state_n   = SHIFT_LO;
          sck_n     = 1'b0;
          bit_cnt_n = bit_cnt + 1'b1;
          // The next bit is presented on the falling edge; after bit 0 the line parks low.
          for (int i = 0; i < 4; i++) begin
            sh_n[i]   = sh_q[i] << 1;
            mosi_n[i] = (bit_cnt == BIT_LAST) ? 1'b0 : (en_q[i] & sh_q[i][WIDTH-2]);
          end
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          if (bit_cnt == BIT_ALL) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            cs_n    = '1;
            mosi_n  = '0;
          end else begin
            state_n = SHIFT_HI;
            sck_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the shadow words are ordinary flops, so they are reset along with the
  // rest of the state; nothing here is a RAM that must skip reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      en_q    <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= '0;
      cs_q    <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the same
      // pre-edge values regardless of statement order.
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      en_q    <= en_n;
      sh_q    <= sh_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      ovr_q   <= ovr_n;
      sck_q   <= sck_n;
      mosi_q  <= mosi_n;
      cs_q    <= cs_n;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.overrun         = ovr_q;
  assign bus.spi_sck         = sck_q;
  assign bus.pc_mosi         = mosi_q[0];
  assign bus.imem_data_mosi  = mosi_q[1];
  assign bus.dmem_wdata_mosi = mosi_q[2];
  assign bus.dmem_rdata_mosi = mosi_q[3];
  assign bus.pc_cs           = cs_q[0];
  assign bus.imem_data_cs    = cs_q[1];
  assign bus.dmem_wdata_cs   = cs_q[2];
  assign bus.dmem_rdata_cs   = cs_q[3];
endmodule

// File: tb/tb_spi_trace_tx.sv
// Bench for spi_trace_tx: a default build (32-bit, CLKDIV=2) and a small build
// (8-bit, CLKDIV=1), both decoded by a mode-0 SPI receiver model.
module tb_spi_trace_tx;
  localparam int WA = 32;
  localparam int CA = 2;
  localparam int WB = 8;
  localparam int CB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_trace_tx_if #(.WIDTH(WA)) a_if ();
  spi_trace_tx_if #(.WIDTH(WB)) b_if ();

  spi_trace_tx #(.WIDTH(WA), .CLKDIV(CA)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  spi_trace_tx #(.WIDTH(WB), .CLKDIV(CB)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  typedef logic [3:0][31:0] words_t;

  typedef struct packed {
    int unsigned busy;
    int unsigned rises;
    int unsigned ovr;
    int unsigned viol;
    words_t      cap;
  } rec_t;

  typedef struct packed {
    int unsigned busy_len;
    int unsigned rises;
    int unsigned ovr;
    words_t      w;
  } exp_t;

  rec_t       acc [2];
  logic       prev_sck [2];
  logic [3:0] cur_en [2];
  logic [3:0] cs_prev [2];
  logic [3:0] cs_now [2];
  rec_t       got_q [$];
  exp_t       exp_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receiver model: samples MOSI on each SCK rising edge for selected channels,
  // and polices the idle/select levels every cycle.
  task automatic monitor(input int d, input logic busy, input logic done, input logic ovr,
                         input logic sck, input logic [3:0] mosi, input logic [3:0] cs);
    if (busy === 1'b1) begin
      acc[d].busy += 1;
      if (cs !== ~cur_en[d] || (mosi & ~cur_en[d]) !== 4'h0) acc[d].viol += 1;
    end else if (cs !== 4'hF || sck !== 1'b0 || mosi !== 4'h0) begin
      acc[d].viol += 1;
    end
    if (ovr === 1'b1) acc[d].ovr += 1;
    if (sck === 1'b1 && prev_sck[d] === 1'b0) begin
      acc[d].rises += 1;
      for (int i = 0; i < 4; i++)
        if (cs[i] === 1'b0) acc[d].cap[i] = {acc[d].cap[i][30:0], mosi[i]};
    end
    prev_sck[d] = sck;
    cs_prev[d]  = cs_now[d];
    cs_now[d]   = cs;
    if (done === 1'b1) begin
      got_q.push_back(acc[d]);
      acc[d] = '0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor(0, a_if.busy, a_if.done, a_if.overrun, a_if.spi_sck,
            {a_if.dmem_rdata_mosi, a_if.dmem_wdata_mosi, a_if.imem_data_mosi, a_if.pc_mosi},
            {a_if.dmem_rdata_cs, a_if.dmem_wdata_cs, a_if.imem_data_cs, a_if.pc_cs});
    monitor(1, b_if.busy, b_if.done, b_if.overrun, b_if.spi_sck,
            {b_if.dmem_rdata_mosi, b_if.dmem_wdata_mosi, b_if.imem_data_mosi, b_if.pc_mosi},
            {b_if.dmem_rdata_cs, b_if.dmem_wdata_cs, b_if.imem_data_cs, b_if.pc_cs});
  endtask

  function automatic words_t rand_words();
    words_t r;
    for (int i = 0; i < 4; i++) r[i] = $urandom();
    return r;
  endfunction

  task automatic drive_words(input int d, input words_t w);
    if (d == 0) begin
      a_if.pc = w[0]; a_if.imem_data = w[1]; a_if.dmem_wdata = w[2]; a_if.dmem_rdata = w[3];
    end else begin
      b_if.pc = w[0][WB-1:0]; b_if.imem_data = w[1][WB-1:0];
      b_if.dmem_wdata = w[2][WB-1:0]; b_if.dmem_rdata = w[3][WB-1:0];
    end
  endtask

  // Issue a start from idle; the expected frame is derived from the words,
  // the enable mask and the frame-length rule (2*WIDTH+1)*CLKDIV.
  task automatic launch(input int d, input logic [3:0] en, input words_t w, input int unsigned ovr_exp);
    exp_t        e;
    logic [31:0] mask;
    int          width, div;
    width = (d == 0) ? WA : WB;
    div   = (d == 0) ? CA : CB;
    mask  = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    e.busy_len = (2 * width + 1) * div;
    e.rises    = width;
    e.ovr      = ovr_exp;
    for (int i = 0; i < 4; i++) e.w[i] = en[i] ? (w[i] & mask) : 32'h0;
    exp_q.push_back(e);
    cur_en[d] = en;
    drive_words(d, w);
    if (d == 0) begin a_if.chan_en = en; a_if.start = 1'b1; end
    else        begin b_if.chan_en = en; b_if.start = 1'b1; end
    step();
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    a_if.chan_en = 4'($urandom());
    b_if.chan_en = 4'($urandom());
    drive_words(d, rand_words());
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n, k;
    n = got_q.size();
    k = 0;
    while (got_q.size() == n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, got_q.size() > n, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    rec_t g;
    exp_t e;
    check({tag, "_frames"}, got_q.size(), 1);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_busy_len"}, g.busy, e.busy_len);
      check({tag, "_sck_rises"}, g.rises, e.rises);
      check({tag, "_overrun"}, g.ovr, e.ovr);
      check({tag, "_pin_levels"}, g.viol, 0);
      check({tag, "_pc"}, g.cap[0], e.w[0]);
      check({tag, "_imem_data"}, g.cap[1], e.w[1]);
      check({tag, "_dmem_wdata"}, g.cap[2], e.w[2]);
      check({tag, "_dmem_rdata"}, g.cap[3], e.w[3]);
    end
    got_q.delete();
  endtask

  initial begin
    words_t w;
    int     gap;
    for (int d = 0; d < 2; d++) begin
      acc[d] = '0; prev_sck[d] = 1'b0; cur_en[d] = 4'h0; cs_prev[d] = 4'hF; cs_now[d] = 4'hF;
    end
    a_if.start = 1'b0; a_if.chan_en = 4'h0; drive_words(0, '0);
    b_if.start = 1'b0; b_if.chan_en = 4'h0; drive_words(1, '0);

    // Reset held for 3 cycles while start toggles.
    for (int k = 0; k < 3; k++) begin
      a_if.start = k[0];
      b_if.start = k[0];
      a_if.chan_en = 4'hF;
      step();
      check("rst_busy", a_if.busy, 1'b0);
      check("rst_sck", a_if.spi_sck, 1'b0);
      check("rst_cs", {a_if.dmem_rdata_cs, a_if.dmem_wdata_cs, a_if.imem_data_cs, a_if.pc_cs}, 4'hF);
      check("rst_mosi", {a_if.dmem_rdata_mosi, a_if.dmem_wdata_mosi, a_if.imem_data_mosi, a_if.pc_mosi}, 4'h0);
    end
    check("rst_done_ovr", {a_if.done, a_if.overrun, b_if.busy}, 3'b000);
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst_idle", a_if.busy, 1'b0);
    acc[0] = '0; acc[1] = '0;
    got_q.delete();

    // Single frame, all channels.
    w[0] = 32'h8000_0001; w[1] = 32'hDEAD_BEEF; w[2] = 32'h0; w[3] = 32'hFFFF_FFFF;
    launch(0, 4'hF, w, 0);
    wait_done("single", 300);
    check_frame("single");

    // Channel mask 0101.
    launch(0, 4'b0101, rand_words(), 0);
    wait_done("mask", 300);
    check_frame("mask");

    // Start 10 cycles into a frame is dropped.
    launch(0, 4'hF, rand_words(), 1);
    repeat (9) step();
    a_if.start = 1'b1;
    a_if.chan_en = 4'h0;
    drive_words(0, rand_words());
    step();
    a_if.start = 1'b0;
    check("overrun_pulse", a_if.overrun, 1'b1);
    step();
    check("overrun_one_cycle", a_if.overrun, 1'b0);
    wait_done("overrun", 300);
    check_frame("overrun");

    // Back-to-back: second start in the done cycle.
    launch(0, 4'hF, rand_words(), 0);
    wait_done("b2b_first", 300);
    check("b2b_cs_low_before_done", cs_prev[0], 4'h0);
    check("b2b_cs_high_in_done", cs_now[0], 4'hF);
    check_frame("b2b_first");
    w = rand_words();
    w[0] = 32'h1234_5678;
    w[1] = 32'hA5A5_A5A5;
    launch(0, 4'hF, w, 0);
    check("b2b_cs_low_after_gap", cs_now[0], 4'h0);
    wait_done("b2b_second", 300);
    check_frame("b2b_second");

    // Random frames with random masks and 0..3 idle cycles between them.
    for (int f = 0; f < 4; f++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      launch(0, 4'($urandom()), rand_words(), 0);
      wait_done("rand", 300);
      check_frame("rand");
    end

    // Reset 40 cycles into a frame aborts it without a done pulse.
    launch(0, 4'hF, rand_words(), 0);
    repeat (39) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", a_if.busy, 1'b0);
    check("midrst_sck", a_if.spi_sck, 1'b0);
    check("midrst_cs", cs_now[0], 4'hF);
    check("midrst_done", a_if.done, 1'b0);
    void'(exp_q.pop_front());
    acc[0] = '0;
    repeat (150) step();
    check("midrst_no_done", got_q.size(), 0);
    got_q.delete();
    acc[0] = '0;
    launch(0, 4'hF, rand_words(), 0);
    wait_done("after_rst", 300);
    check_frame("after_rst");

    // Small build: 8-bit words at CLKDIV=1, 17-cycle frame.
    w = rand_words();
    w[0] = 32'h0000_00C3;
    launch(1, 4'hF, w, 0);
    wait_done("small", 60);
    check_frame("small");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
